queue_reader: RTL and testbench

- Read-side controller for the 4-bit, 8-entry push/pop queue.
- Issues pop commands on the queue's enable/push_pop interface and captures the head entry from q_data.
- Delivers captured entries downstream on a valid/ready stream.
- Runs as a software-started burst: fixed length, or drain-until-empty. Sits between the queue and the downstream serializer.

---
 rtl/queue_reader_pkg.sv | 18 +
 rtl/queue_reader_obuf.sv | 65 ++++++
 rtl/queue_reader.sv | 121 ++++++++++++
 tb/tb_queue_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/queue_reader_pkg.sv
// Shared constants and types for the read side of the 4-bit, 8-entry queue.
package queue_reader_pkg;

    localparam int DATA_W     = 4;
    localparam int Q_DEPTH    = 8;
    localparam int LEN_W      = 4;
    localparam int OBUF_DEPTH = 2;

    localparam logic CMD_PUSH = 1'b1;
    localparam logic CMD_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/queue_reader_obuf.sv
// Two-entry skid FIFO between the queue pop path and the downstream stream.
module queue_reader_obuf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push_ok, pop_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    // next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= {2{{W{1'b0}}}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/queue_reader.sv
// Burst pop controller: pops the queue head into a skid buffer and streams it out.
module queue_reader #(
    parameter int DATA_W     = 4,
    parameter int OBUF_DEPTH = 2,
    parameter int LEN_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] q_data,
    input  logic              q_empty,
    output logic              q_enable,
    output logic              q_push_pop,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  pop_cnt
);

    import queue_reader_pkg::*;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic               done_q, done_d;
    logic [1:0]         obuf_count;
    logic [DATA_W-1:0]  obuf_head;
    logic               limit_hit;
    logic               pop_fire;
    logic               xfer;

    assign limit_hit = (len_q != {LEN_W{1'b0}}) && (pop_cnt_q == len_q);
    // Pop decision is purely combinational so it always sees the current q_empty.
    assign pop_fire  = (state_q == DRAIN) && !q_empty
                       && (obuf_count < 2'(OBUF_DEPTH)) && !abort && !limit_hit;
    assign m_valid   = (obuf_count != 2'd0);
    assign xfer      = m_valid && m_ready;

    queue_reader_obuf #(.W(DATA_W)) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .push      (pop_fire),
        .push_data (q_data),
        .pop       (xfer),
        .head      (obuf_head),
        .count     (obuf_count)
    );

    // burst FSM, pop counter and completion pulse
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        done_d    = 1'b0;
        if (pop_fire && (pop_cnt_q != {LEN_W{1'b1}})) begin
            pop_cnt_d = pop_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            pop_cnt_d = pop_cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = burst_len;
                    pop_cnt_d = {LEN_W{1'b0}};
                    state_d   = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = FLUSH;
                end else if ((len_q != {LEN_W{1'b0}}) && (pop_cnt_d == len_q)) begin
                    state_d = FLUSH;
                end else if ((len_q == {LEN_W{1'b0}}) && q_empty && !pop_fire) begin
                    state_d = FLUSH;
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (obuf_count == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= {LEN_W{1'b0}};
            pop_cnt_q <= {LEN_W{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pop_cnt_q <= pop_cnt_d;
            done_q    <= done_d;
        end
    end

    assign q_enable   = pop_fire;
    assign q_push_pop = CMD_POP;
    assign m_data     = obuf_head;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pop_cnt    = pop_cnt_q;

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader with a behavioural queue model and a data scoreboard.
module tb_queue_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] burst_len;
    logic       abort;
    logic [3:0] q_data;
    logic       q_empty;
    logic       q_enable;
    logic       q_push_pop;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic [3:0] pop_cnt;

    logic [3:0] qm[$];
    logic [3:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int pops_seen = 0;
    int delivered = 0;
    int done_cnt = 0;

    queue_reader dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .q_data     (q_data),
        .q_empty    (q_empty),
        .q_enable   (q_enable),
        .q_push_pop (q_push_pop),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .pop_cnt    (pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_q();
        q_empty = (qm.size() == 0);
        q_data  = (qm.size() != 0) ? qm[0] : 4'h0;
    endtask

    task automatic push_q(input logic [3:0] v);
        qm.push_back(v);
        sync_q();
    endtask

    // One clock: sample at the negedge side, let the edge happen, update the queue model.
    task automatic tick();
        logic pop_now;
        logic [3:0] exp_d;
        #1;
        pop_now = q_enable;
        if (pop_now) begin
            pops_seen++;
            chk("q_push_pop", 32'(q_push_pop), 32'd0);
        end
        if (m_valid && m_ready) begin
            delivered++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                exp_d = sb.pop_front();
                chk("m_data", 32'(m_data), 32'(exp_d));
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        if (pop_now) begin
            if (qm.size() == 0) begin
                chk("pop_of_empty", 32'd1, 32'd0);
            end else begin
                sb.push_back(qm[0]);
                void'(qm.pop_front());
            end
        end
        sync_q();
        @(negedge clk);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic clear_stats();
        pops_seen = 0;
        delivered = 0;
        done_cnt  = 0;
    endtask

    task automatic kick(input logic [3:0] len);
        burst_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; burst_len = 4'd0; abort = 1'b0; m_ready = 1'b0;
        sync_q();
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pop_cnt", 32'(pop_cnt), 32'd0);
        chk("rst_q_enable", 32'(q_enable), 32'd0);
        rst_n = 1'b1;
        tick();

        // drain mode, three entries, downstream always ready
        clear_stats();
        push_q(4'h3); push_q(4'h7); push_q(4'hA);
        m_ready = 1'b1;
        kick(4'd0);
        tick(); tick(); tick();
        chk("t1_pops_consecutive", 32'(pops_seen), 32'd3);
        chk("t1_pop_cnt", 32'(pop_cnt), 32'd3);
        tick();
        chk("t1_delivered_consecutive", 32'(delivered), 32'd3);
        run_until_done("t1_done", 20);
        tick(); tick();
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // fixed burst of 5 from a full queue
        clear_stats();
        for (int i = 0; i < 8; i++) push_q(4'(i + 1));
        kick(4'd5);
        run_until_done("t2_done", 40);
        chk("t2_pops", 32'(pops_seen), 32'd5);
        chk("t2_pop_cnt", 32'(pop_cnt), 32'd5);
        chk("t2_q_left", 32'(qm.size()), 32'd3);
        chk("t2_q_empty", 32'(q_empty), 32'd0);
        chk("t2_delivered", 32'(delivered), 32'd5);

        // backpressure: buffer fills at two entries and head stays stable
        qm.delete(); sync_q(); clear_stats();
        push_q(4'h9); push_q(4'h4); push_q(4'hC); push_q(4'h2);
        m_ready = 1'b0;
        kick(4'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) chk("t3_m_data_hold", 32'(m_data), 32'h9);
        end
        chk("t3_pops_stalled", 32'(pops_seen), 32'd2);
        chk("t3_m_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        run_until_done("t3_done", 40);
        chk("t3_pops", 32'(pops_seen), 32'd4);
        chk("t3_delivered", 32'(delivered), 32'd4);

        // burst waits on an empty queue, then resumes
        clear_stats();
        push_q(4'h5); push_q(4'h6);
        kick(4'd4);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_pops_wait", 32'(pops_seen), 32'd2);
        chk("t4_busy_wait", 32'(busy), 32'd1);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        push_q(4'hD); push_q(4'hE);
        run_until_done("t4_done", 40);
        chk("t4_pops", 32'(pops_seen), 32'd4);
        chk("t4_pop_cnt", 32'(pop_cnt), 32'd4);
        chk("t4_delivered", 32'(delivered), 32'd4);

        // abort after two pops of a six-pop burst
        clear_stats();
        for (int i = 0; i < 6; i++) push_q(4'(4'hF - i));
        kick(4'd6);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_until_done("t5_done", 40);
        chk("t5_pops", 32'(pops_seen), 32'd2);
        chk("t5_pop_cnt", 32'(pop_cnt), 32'd2);
        chk("t5_delivered", 32'(delivered), 32'd2);

        // reset mid-burst with two entries buffered
        qm.delete(); sync_q(); clear_stats();
        push_q(4'h1); push_q(4'h8); push_q(4'hB); push_q(4'h6);
        m_ready = 1'b0;
        kick(4'd0);
        tick(); tick(); tick();
        chk("t6_buffered", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_pop_cnt", 32'(pop_cnt), 32'd0);
        sb.delete();
        tick(); tick();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        clear_stats();
        kick(4'd2);
        run_until_done("t6_restart_done", 40);
        chk("t6_restart_pops", 32'(pops_seen), 32'd2);
        chk("t6_restart_delivered", 32'(delivered), 32'd2);
        chk("t6_q_drained", 32'(q_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
